// File: rtl/rsp_s1_prep_ahbic.sv
// rsp_s1_prep_ahbic
// Single-master, seven-slave AHB interconnect for the rsp_s1_prep register space.
// The master address is decoded into seven 1 KB windows, HADDRS0[12:10] = 0..6,
// which alias every 8 KB. Window 7 goes to an internal default slave that answers
// NONSEQ/SEQ transfers with a two-cycle ERROR response.
//
// Ports
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   REMAP                    accepted but has no effect on decode
//   H*S0 (in)                master address/control/write data, system HREADYS0
//   HRDATAMn/HREADYOUTMn/HRESPMn (in)  slave n data-phase response, n = 0..6
//   HSELMn (out)             slave n select (address phase, combinational)
//   H*Mn (out)               address/control/write data broadcast to every slave
//   HREADYMUXMn (out)        system HREADY broadcast to every slave
//   HRDATAS0/HREADYOUTS0/HRESPS0 (out)  response of the slave owning the data phase
//   SCANENABLE, SCANINHCLK, SCANOUTHCLK  scan placeholders, output tied low
//
// Default slave states
//   state    | meaning
//   DEF_IDLE | no error in progress; answers OKAY with ready high
//   DEF_ERR1 | first ERROR cycle, ready low
//   DEF_ERR2 | second ERROR cycle, ready high; may re-enter DEF_ERR1

module rsp_s1_prep_ahbic #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          REMAP,
    input  logic          HSELS0,
    input  logic [AW-1:0] HADDRS0,
    input  logic [1:0]    HTRANSS0,
    input  logic          HWRITES0,
    input  logic [2:0]    HSIZES0,
    input  logic [2:0]    HBURSTS0,
    input  logic [3:0]    HPROTS0,
    input  logic [3:0]    HMASTERS0,
    input  logic          HMASTLOCKS0,
    input  logic [DW-1:0] HWDATAS0,
    input  logic          HREADYS0,
    input  logic [DW-1:0] HRDATAM0,
    input  logic [DW-1:0] HRDATAM1,
    input  logic [DW-1:0] HRDATAM2,
    input  logic [DW-1:0] HRDATAM3,
    input  logic [DW-1:0] HRDATAM4,
    input  logic [DW-1:0] HRDATAM5,
    input  logic [DW-1:0] HRDATAM6,
    input  logic          HREADYOUTM0,
    input  logic          HREADYOUTM1,
    input  logic          HREADYOUTM2,
    input  logic          HREADYOUTM3,
    input  logic          HREADYOUTM4,
    input  logic          HREADYOUTM5,
    input  logic          HREADYOUTM6,
    input  logic [1:0]    HRESPM0,
    input  logic [1:0]    HRESPM1,
    input  logic [1:0]    HRESPM2,
    input  logic [1:0]    HRESPM3,
    input  logic [1:0]    HRESPM4,
    input  logic [1:0]    HRESPM5,
    input  logic [1:0]    HRESPM6,
    input  logic          SCANENABLE,
    input  logic          SCANINHCLK,
    output logic          HSELM0,
    output logic          HSELM1,
    output logic          HSELM2,
    output logic          HSELM3,
    output logic          HSELM4,
    output logic          HSELM5,
    output logic          HSELM6,
    output logic [AW-1:0] HADDRM0,
    output logic [AW-1:0] HADDRM1,
    output logic [AW-1:0] HADDRM2,
    output logic [AW-1:0] HADDRM3,
    output logic [AW-1:0] HADDRM4,
    output logic [AW-1:0] HADDRM5,
    output logic [AW-1:0] HADDRM6,
    output logic [1:0]    HTRANSM0,
    output logic [1:0]    HTRANSM1,
    output logic [1:0]    HTRANSM2,
    output logic [1:0]    HTRANSM3,
    output logic [1:0]    HTRANSM4,
    output logic [1:0]    HTRANSM5,
    output logic [1:0]    HTRANSM6,
    output logic          HWRITEM0,
    output logic          HWRITEM1,
    output logic          HWRITEM2,
    output logic          HWRITEM3,
    output logic          HWRITEM4,
    output logic          HWRITEM5,
    output logic          HWRITEM6,
    output logic [2:0]    HSIZEM0,
    output logic [2:0]    HSIZEM1,
    output logic [2:0]    HSIZEM2,
    output logic [2:0]    HSIZEM3,
    output logic [2:0]    HSIZEM4,
    output logic [2:0]    HSIZEM5,
    output logic [2:0]    HSIZEM6,
    output logic [2:0]    HBURSTM0,
    output logic [2:0]    HBURSTM1,
    output logic [2:0]    HBURSTM2,
    output logic [2:0]    HBURSTM3,
    output logic [2:0]    HBURSTM4,
    output logic [2:0]    HBURSTM5,
    output logic [2:0]    HBURSTM6,
    output logic [3:0]    HPROTM0,
    output logic [3:0]    HPROTM1,
    output logic [3:0]    HPROTM2,
    output logic [3:0]    HPROTM3,
    output logic [3:0]    HPROTM4,
    output logic [3:0]    HPROTM5,
    output logic [3:0]    HPROTM6,
    output logic [3:0]    HMASTERM0,
    output logic [3:0]    HMASTERM1,
    output logic [3:0]    HMASTERM2,
    output logic [3:0]    HMASTERM3,
    output logic [3:0]    HMASTERM4,
    output logic [3:0]    HMASTERM5,
    output logic [3:0]    HMASTERM6,
    output logic          HMASTLOCKM0,
    output logic          HMASTLOCKM1,
    output logic          HMASTLOCKM2,
    output logic          HMASTLOCKM3,
    output logic          HMASTLOCKM4,
    output logic          HMASTLOCKM5,
    output logic          HMASTLOCKM6,
    output logic [DW-1:0] HWDATAM0,
    output logic [DW-1:0] HWDATAM1,
    output logic [DW-1:0] HWDATAM2,
    output logic [DW-1:0] HWDATAM3,
    output logic [DW-1:0] HWDATAM4,
    output logic [DW-1:0] HWDATAM5,
    output logic [DW-1:0] HWDATAM6,
    output logic          HREADYMUXM0,
    output logic          HREADYMUXM1,
    output logic          HREADYMUXM2,
    output logic          HREADYMUXM3,
    output logic          HREADYMUXM4,
    output logic          HREADYMUXM5,
    output logic          HREADYMUXM6,
    output logic [DW-1:0] HRDATAS0,
    output logic          HREADYOUTS0,
    output logic [1:0]    HRESPS0,
    output logic          SCANOUTHCLK
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_t;

    logic [2:0]    region;
    logic          dp_valid;
    logic [2:0]    dp_index;
    def_state_t    def_state;
    logic          def_ready;
    logic [1:0]    def_resp;
    logic          def_accept;

    // Entry 7 is the default slave; its real values are substituted in the mux.
    logic [DW-1:0] slv_rdata [0:7];
    logic          slv_ready [0:7];
    logic [1:0]    slv_resp  [0:7];

    logic          unused_inputs;

    assign region = HADDRS0[12:10];

    // Address phase: selects decoded, everything else broadcast unconditionally.
    assign HSELM0 = HSELS0 & (region == 3'd0);
    assign HSELM1 = HSELS0 & (region == 3'd1);
    assign HSELM2 = HSELS0 & (region == 3'd2);
    assign HSELM3 = HSELS0 & (region == 3'd3);
    assign HSELM4 = HSELS0 & (region == 3'd4);
    assign HSELM5 = HSELS0 & (region == 3'd5);
    assign HSELM6 = HSELS0 & (region == 3'd6);

    assign {HADDRM0, HADDRM1, HADDRM2, HADDRM3, HADDRM4, HADDRM5, HADDRM6} = {7{HADDRS0}};
    assign {HTRANSM0, HTRANSM1, HTRANSM2, HTRANSM3, HTRANSM4, HTRANSM5, HTRANSM6} = {7{HTRANSS0}};
    assign {HWRITEM0, HWRITEM1, HWRITEM2, HWRITEM3, HWRITEM4, HWRITEM5, HWRITEM6} = {7{HWRITES0}};
    assign {HSIZEM0, HSIZEM1, HSIZEM2, HSIZEM3, HSIZEM4, HSIZEM5, HSIZEM6} = {7{HSIZES0}};
    assign {HBURSTM0, HBURSTM1, HBURSTM2, HBURSTM3, HBURSTM4, HBURSTM5, HBURSTM6} = {7{HBURSTS0}};
    assign {HPROTM0, HPROTM1, HPROTM2, HPROTM3, HPROTM4, HPROTM5, HPROTM6} = {7{HPROTS0}};
    assign {HMASTERM0, HMASTERM1, HMASTERM2, HMASTERM3, HMASTERM4, HMASTERM5, HMASTERM6} =
        {7{HMASTERS0}};
    assign {HMASTLOCKM0, HMASTLOCKM1, HMASTLOCKM2, HMASTLOCKM3, HMASTLOCKM4, HMASTLOCKM5,
            HMASTLOCKM6} = {7{HMASTLOCKS0}};
    assign {HWDATAM0, HWDATAM1, HWDATAM2, HWDATAM3, HWDATAM4, HWDATAM5, HWDATAM6} = {7{HWDATAS0}};
    assign {HREADYMUXM0, HREADYMUXM1, HREADYMUXM2, HREADYMUXM3, HREADYMUXM4, HREADYMUXM5,
            HREADYMUXM6} = {7{HREADYS0}};

    assign SCANOUTHCLK   = 1'b0;
    assign unused_inputs = REMAP ^ SCANENABLE ^ SCANINHCLK;

    assign slv_rdata[0] = HRDATAM0;
    assign slv_rdata[1] = HRDATAM1;
    assign slv_rdata[2] = HRDATAM2;
    assign slv_rdata[3] = HRDATAM3;
    assign slv_rdata[4] = HRDATAM4;
    assign slv_rdata[5] = HRDATAM5;
    assign slv_rdata[6] = HRDATAM6;
    assign slv_rdata[7] = '0;

    assign slv_ready[0] = HREADYOUTM0;
    assign slv_ready[1] = HREADYOUTM1;
    assign slv_ready[2] = HREADYOUTM2;
    assign slv_ready[3] = HREADYOUTM3;
    assign slv_ready[4] = HREADYOUTM4;
    assign slv_ready[5] = HREADYOUTM5;
    assign slv_ready[6] = HREADYOUTM6;
    assign slv_ready[7] = 1'b1;

    assign slv_resp[0] = HRESPM0;
    assign slv_resp[1] = HRESPM1;
    assign slv_resp[2] = HRESPM2;
    assign slv_resp[3] = HRESPM3;
    assign slv_resp[4] = HRESPM4;
    assign slv_resp[5] = HRESPM5;
    assign slv_resp[6] = HRESPM6;
    assign slv_resp[7] = RESP_OKAY;

    // Data-phase owner; frozen while the current transfer is stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_index <= 3'd0;
        end else if (HREADYS0) begin
            dp_valid <= HSELS0;
            dp_index <= region;
        end
    end

    // An active transfer into the unmapped window accepted this cycle.
    assign def_accept = HREADYS0 & HSELS0 & (region == 3'd7) & HTRANSS0[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            def_state <= DEF_IDLE;
            def_ready <= 1'b1;
            def_resp  <= RESP_OKAY;
        end else begin
            case (def_state)
                DEF_IDLE, DEF_ERR2: begin
                    if (def_accept) begin
                        def_state <= DEF_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= RESP_ERROR;
                    end else begin
                        def_state <= DEF_IDLE;
                        def_ready <= 1'b1;
                        def_resp  <= RESP_OKAY;
                    end
                end
                DEF_ERR1: begin
                    def_state <= DEF_ERR2;
                    def_ready <= 1'b1;
                    def_resp  <= RESP_ERROR;
                end
                default: begin
                    def_state <= DEF_IDLE;
                    def_ready <= 1'b1;
                    def_resp  <= RESP_OKAY;
                end
            endcase
        end
    end

    always_comb begin
        HRDATAS0    = '0;
        HREADYOUTS0 = 1'b1;
        HRESPS0     = RESP_OKAY;
        if (dp_valid) begin
            if (dp_index == 3'd7) begin
                HREADYOUTS0 = def_ready;
                HRESPS0     = def_resp;
            end else begin
                HRDATAS0    = slv_rdata[dp_index];
                HREADYOUTS0 = slv_ready[dp_index];
                HRESPS0     = slv_resp[dp_index];
            end
        end
    end

endmodule

// File: tb/tb_rsp_s1_prep_ahbic.sv
module tb_rsp_s1_prep_ahbic;

    logic        hclk;
    logic        hresetn;
    logic        remap;
    logic        hsel_s;
    logic [31:0] haddr_s;
    logic [1:0]  htrans_s;
    logic        hwrite_s;
    logic [2:0]  hsize_s;
    logic [2:0]  hburst_s;
    logic [3:0]  hprot_s;
    logic [3:0]  hmaster_s;
    logic        hmastlock_s;
    logic [31:0] hwdata_s;
    logic        hready_s;
    logic        scan_en;
    logic        scan_in;

    logic [31:0] rdata_m    [7];
    logic        readyout_m [7];
    logic [1:0]  resp_m     [7];

    logic        sel_m      [7];
    logic [31:0] addr_m     [7];
    logic [1:0]  trans_m    [7];
    logic        write_m    [7];
    logic [2:0]  size_m     [7];
    logic [2:0]  burst_m    [7];
    logic [3:0]  prot_m     [7];
    logic [3:0]  master_m   [7];
    logic        mastlock_m [7];
    logic [31:0] wdata_m    [7];
    logic        readymux_m [7];

    logic [31:0] hrdata_s0;
    logic        hreadyout_s0;
    logic [1:0]  hresp_s0;
    logic        scan_out;

    int errors = 0;
    int checks = 0;

    // System HREADY is the master-side ready fed back, as in a single-master system.
    assign hready_s = hreadyout_s0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    rsp_s1_prep_ahbic #(.AW(32), .DW(32)) dut (
        .HCLK(hclk), .HRESETn(hresetn), .REMAP(remap), .HSELS0(hsel_s), .HADDRS0(haddr_s),
        .HTRANSS0(htrans_s), .HWRITES0(hwrite_s), .HSIZES0(hsize_s), .HBURSTS0(hburst_s),
        .HPROTS0(hprot_s), .HMASTERS0(hmaster_s), .HMASTLOCKS0(hmastlock_s),
        .HWDATAS0(hwdata_s), .HREADYS0(hready_s),
        .HRDATAM0(rdata_m[0]), .HRDATAM1(rdata_m[1]), .HRDATAM2(rdata_m[2]),
        .HRDATAM3(rdata_m[3]), .HRDATAM4(rdata_m[4]), .HRDATAM5(rdata_m[5]),
        .HRDATAM6(rdata_m[6]),
        .HREADYOUTM0(readyout_m[0]), .HREADYOUTM1(readyout_m[1]), .HREADYOUTM2(readyout_m[2]),
        .HREADYOUTM3(readyout_m[3]), .HREADYOUTM4(readyout_m[4]), .HREADYOUTM5(readyout_m[5]),
        .HREADYOUTM6(readyout_m[6]),
        .HRESPM0(resp_m[0]), .HRESPM1(resp_m[1]), .HRESPM2(resp_m[2]), .HRESPM3(resp_m[3]),
        .HRESPM4(resp_m[4]), .HRESPM5(resp_m[5]), .HRESPM6(resp_m[6]),
        .SCANENABLE(scan_en), .SCANINHCLK(scan_in),
        .HSELM0(sel_m[0]), .HSELM1(sel_m[1]), .HSELM2(sel_m[2]), .HSELM3(sel_m[3]),
        .HSELM4(sel_m[4]), .HSELM5(sel_m[5]), .HSELM6(sel_m[6]),
        .HADDRM0(addr_m[0]), .HADDRM1(addr_m[1]), .HADDRM2(addr_m[2]), .HADDRM3(addr_m[3]),
        .HADDRM4(addr_m[4]), .HADDRM5(addr_m[5]), .HADDRM6(addr_m[6]),
        .HTRANSM0(trans_m[0]), .HTRANSM1(trans_m[1]), .HTRANSM2(trans_m[2]),
        .HTRANSM3(trans_m[3]), .HTRANSM4(trans_m[4]), .HTRANSM5(trans_m[5]),
        .HTRANSM6(trans_m[6]),
        .HWRITEM0(write_m[0]), .HWRITEM1(write_m[1]), .HWRITEM2(write_m[2]),
        .HWRITEM3(write_m[3]), .HWRITEM4(write_m[4]), .HWRITEM5(write_m[5]),
        .HWRITEM6(write_m[6]),
        .HSIZEM0(size_m[0]), .HSIZEM1(size_m[1]), .HSIZEM2(size_m[2]), .HSIZEM3(size_m[3]),
        .HSIZEM4(size_m[4]), .HSIZEM5(size_m[5]), .HSIZEM6(size_m[6]),
        .HBURSTM0(burst_m[0]), .HBURSTM1(burst_m[1]), .HBURSTM2(burst_m[2]),
        .HBURSTM3(burst_m[3]), .HBURSTM4(burst_m[4]), .HBURSTM5(burst_m[5]),
        .HBURSTM6(burst_m[6]),
        .HPROTM0(prot_m[0]), .HPROTM1(prot_m[1]), .HPROTM2(prot_m[2]), .HPROTM3(prot_m[3]),
        .HPROTM4(prot_m[4]), .HPROTM5(prot_m[5]), .HPROTM6(prot_m[6]),
        .HMASTERM0(master_m[0]), .HMASTERM1(master_m[1]), .HMASTERM2(master_m[2]),
        .HMASTERM3(master_m[3]), .HMASTERM4(master_m[4]), .HMASTERM5(master_m[5]),
        .HMASTERM6(master_m[6]),
        .HMASTLOCKM0(mastlock_m[0]), .HMASTLOCKM1(mastlock_m[1]), .HMASTLOCKM2(mastlock_m[2]),
        .HMASTLOCKM3(mastlock_m[3]), .HMASTLOCKM4(mastlock_m[4]), .HMASTLOCKM5(mastlock_m[5]),
        .HMASTLOCKM6(mastlock_m[6]),
        .HWDATAM0(wdata_m[0]), .HWDATAM1(wdata_m[1]), .HWDATAM2(wdata_m[2]),
        .HWDATAM3(wdata_m[3]), .HWDATAM4(wdata_m[4]), .HWDATAM5(wdata_m[5]),
        .HWDATAM6(wdata_m[6]),
        .HREADYMUXM0(readymux_m[0]), .HREADYMUXM1(readymux_m[1]), .HREADYMUXM2(readymux_m[2]),
        .HREADYMUXM3(readymux_m[3]), .HREADYMUXM4(readymux_m[4]), .HREADYMUXM5(readymux_m[5]),
        .HREADYMUXM6(readymux_m[6]),
        .HRDATAS0(hrdata_s0), .HREADYOUTS0(hreadyout_s0), .HRESPS0(hresp_s0),
        .SCANOUTHCLK(scan_out)
    );

    task automatic master_idle();
        hsel_s = 1'b0; haddr_s = '0; htrans_s = 2'b00; hwrite_s = 1'b0;
        hsize_s = 3'd2; hburst_s = 3'd0; hprot_s = 4'h3; hmaster_s = 4'h0;
        hmastlock_s = 1'b0;
    endtask

    task automatic master_xfer(input logic [31:0] a, input logic wr);
        hsel_s = 1'b1; haddr_s = a; htrans_s = 2'b10; hwrite_s = wr;
    endtask

    task automatic slaves_ready();
        for (int n = 0; n < 7; n++) begin
            rdata_m[n] = 32'hDEAD_0000 + n; readyout_m[n] = 1'b1; resp_m[n] = 2'b00;
        end
    endtask

    task automatic check_resp(input string name, input logic [31:0] rd, input logic rdy,
                              input logic [1:0] rsp);
        checks++;
        if (hrdata_s0 !== rd || hreadyout_s0 !== rdy || hresp_s0 !== rsp) begin
            errors++;
            $display("FAIL %s: got rdata=%h ready=%b resp=%b, expected rdata=%h ready=%b resp=%b",
                     name, hrdata_s0, hreadyout_s0, hresp_s0, rd, rdy, rsp);
        end
    endtask

    task automatic check_sel(input string name, input logic [6:0] exp_sel);
        logic [6:0] got;
        for (int n = 0; n < 7; n++) got[n] = sel_m[n];
        checks++;
        if (got !== exp_sel) begin
            errors++;
            $display("FAIL %s: got sel=%b expected sel=%b", name, got, exp_sel);
        end
    endtask

    task automatic test_reset();
        master_idle(); slaves_ready();
        hwdata_s = '0; remap = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        hresetn = 1'b1;
        #2 hresetn = 1'b0;
        #2;
        check_resp("reset_resp", 32'h0, 1'b1, 2'b00);
        check_sel("reset_sel", 7'b0);
        checks++;
        if (scan_out !== 1'b0) begin
            errors++; $display("FAIL reset_scanout: got %b expected 0", scan_out);
        end
        @(negedge hclk) hresetn = 1'b1;
        @(posedge hclk) #1;
    endtask

    task automatic test_write();
        master_xfer(32'h0000_0804, 1'b1);
        @(negedge hclk);
        check_sel("write_addr_sel", 7'b0000100);
        checks++;
        if (addr_m[2] !== 32'h804 || write_m[2] !== 1'b1 || trans_m[2] !== 2'b10) begin
            errors++;
            $display("FAIL write_addr_bcast: got addr=%h wr=%b trans=%b expected 804 1 10",
                     addr_m[2], write_m[2], trans_m[2]);
        end
        @(posedge hclk) #1;
        master_idle();
        hwdata_s = 32'hA5A5_5A5A;
        readyout_m[2] = 1'b0;
        @(negedge hclk);
        checks++;
        if (wdata_m[2] !== 32'hA5A5_5A5A) begin
            errors++; $display("FAIL write_wdata: got %h expected a5a55a5a", wdata_m[2]);
        end
        check_resp("write_wait", 32'hDEAD_0002, 1'b0, 2'b00);
        readyout_m[2] = 1'b1;
        #1;
        check_resp("write_done", 32'hDEAD_0002, 1'b1, 2'b00);
        @(posedge hclk) #1;
    endtask

    task automatic test_wait_read();
        master_xfer(32'h0000_1800, 1'b0);
        @(posedge hclk) #1;
        master_idle();
        rdata_m[6] = 32'h1234_5678;
        readyout_m[6] = 1'b0;
        @(negedge hclk);
        check_resp("read_wait1", 32'h1234_5678, 1'b0, 2'b00);
        @(posedge hclk) #1;
        @(negedge hclk);
        check_resp("read_wait2", 32'h1234_5678, 1'b0, 2'b00);
        @(posedge hclk) #1;
        readyout_m[6] = 1'b1;
        @(negedge hclk);
        check_resp("read_data", 32'h1234_5678, 1'b1, 2'b00);
        @(posedge hclk) #1;
        @(negedge hclk);
        check_resp("read_after_idle", 32'h0, 1'b1, 2'b00);
        @(posedge hclk) #1;
    endtask

    task automatic test_default_slave();
        master_xfer(32'h0000_1C00, 1'b0);
        @(negedge hclk);
        check_sel("unmapped_sel", 7'b0);
        @(posedge hclk) #1;
        master_idle();
        @(negedge hclk);
        check_resp("unmapped_err1", 32'h0, 1'b0, 2'b01);
        @(posedge hclk) #1;
        @(negedge hclk);
        check_resp("unmapped_err2", 32'h0, 1'b1, 2'b01);
        @(posedge hclk) #1;
        @(negedge hclk);
        check_resp("unmapped_back_idle", 32'h0, 1'b1, 2'b00);
        // Unmapped IDLE transfer gets a plain OKAY.
        hsel_s = 1'b1; haddr_s = 32'hFFFF_FC00; htrans_s = 2'b00;
        @(posedge hclk) #1;
        master_idle();
        @(negedge hclk);
        check_resp("unmapped_idle_okay", 32'h0, 1'b1, 2'b00);
        @(posedge hclk) #1;
    endtask

    task automatic test_back_to_back();
        master_xfer(32'h0000_0000, 1'b0);
        @(posedge hclk) #1;
        master_xfer(32'h0000_0400, 1'b0);
        rdata_m[0] = 32'h11; rdata_m[1] = 32'h22;
        @(negedge hclk);
        check_resp("b2b_first", 32'h11, 1'b1, 2'b00);
        check_sel("b2b_addr2_sel", 7'b0000010);
        @(posedge hclk) #1;
        master_idle();
        @(negedge hclk);
        check_resp("b2b_second", 32'h22, 1'b1, 2'b00);
        @(posedge hclk) #1;
    endtask

    task automatic test_reset_mid();
        master_xfer(32'h0000_0C00, 1'b1);
        @(posedge hclk) #1;
        master_idle();
        readyout_m[3] = 1'b0; resp_m[3] = 2'b01;
        @(negedge hclk);
        check_resp("midreset_before", 32'hDEAD_0003, 1'b0, 2'b01);
        #2 hresetn = 1'b0;
        #1;
        check_resp("midreset_async", 32'h0, 1'b1, 2'b00);
        slaves_ready();
        @(negedge hclk) hresetn = 1'b1;
        @(posedge hclk) #1;
    endtask

    // Reference model: tracks which transfer owns the data phase and how many
    // cycles it has lasted; the unmapped window answers ERROR for two cycles.
    task automatic test_random();
        logic        m_valid, m_active;
        int          m_region, m_cycle;
        logic [31:0] e_rd;
        logic        e_rdy;
        logic [1:0]  e_rsp;
        logic [6:0]  e_sel;
        int          pre_err;
        m_valid = 1'b0; m_active = 1'b0; m_region = 0; m_cycle = 0;
        for (int c = 0; c < 600; c++) begin
            hsel_s      = ($urandom_range(0, 3) != 0);
            haddr_s     = $urandom;
            htrans_s    = 2'($urandom_range(0, 3));
            hwrite_s    = 1'($urandom);
            hsize_s     = 3'($urandom);
            hburst_s    = 3'($urandom);
            hprot_s     = 4'($urandom);
            hmaster_s   = 4'($urandom);
            hmastlock_s = 1'($urandom);
            hwdata_s    = $urandom;
            for (int n = 0; n < 7; n++) begin
                rdata_m[n]    = $urandom;
                readyout_m[n] = ($urandom_range(0, 3) != 0);
                resp_m[n]     = 2'($urandom_range(0, 1));
            end
            @(negedge hclk);
            e_rd = 32'h0; e_rdy = 1'b1; e_rsp = 2'b00;
            if (m_valid && m_region < 7) begin
                e_rd = rdata_m[m_region]; e_rdy = readyout_m[m_region]; e_rsp = resp_m[m_region];
            end else if (m_valid && m_active) begin
                e_rdy = (m_cycle != 0); e_rsp = 2'b01;
            end
            check_resp("random_resp", e_rd, e_rdy, e_rsp);
            for (int n = 0; n < 7; n++) e_sel[n] = hsel_s && (haddr_s / 1024) % 8 == n;
            check_sel("random_sel", e_sel);
            pre_err = errors;
            for (int n = 0; n < 7; n++) begin
                if (addr_m[n] !== haddr_s || trans_m[n] !== htrans_s || write_m[n] !== hwrite_s ||
                    size_m[n] !== hsize_s || burst_m[n] !== hburst_s || prot_m[n] !== hprot_s ||
                    master_m[n] !== hmaster_s || mastlock_m[n] !== hmastlock_s ||
                    wdata_m[n] !== hwdata_s || readymux_m[n] !== e_rdy)
                    errors++;
            end
            checks++;
            if (errors != pre_err)
                $display("FAIL random_bcast: cycle %0d addr=%h got slave0 addr=%h wdata=%h readymux=%b",
                         c, haddr_s, addr_m[0], wdata_m[0], readymux_m[0]);
            if (e_rdy) begin
                m_valid  = hsel_s;
                m_region = (haddr_s / 1024) % 8;
                m_active = hsel_s && htrans_s >= 2;
                m_cycle  = 0;
            end else begin
                m_cycle++;
            end
            @(posedge hclk) #1;
        end
        master_idle(); slaves_ready();
    endtask

    initial begin
        test_reset();
        test_write();
        test_wait_read();
        test_default_slave();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
